// File: rtl/itch_message_dispatcher.sv
// ITCH front-end dispatcher: finds message-type bytes in the 64-bit stream and pulses the matching parser start.
// Optional msgCount output is compiled in when ITCH_DISPATCH_MSG_COUNT_EN is defined.
module itch_message_dispatcher #(
    parameter int unsigned LEN_T = 5,
    parameter int unsigned LEN_A = 37,
    parameter int unsigned LEN_D = 19,
    parameter int unsigned LEN_E = 31,
    parameter int unsigned LEN_C = 52
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] dataIn,
    input  logic        dataInValid,
    output logic        dataInReady,
    output logic [63:0] dataOut,
    output logic        dataOutValid,
    output logic        dataOutReplay,
    output logic        startSeconds,
    output logic        startAddOrder,
    output logic        startDelete,
    output logic        startOrderExecuted,
    output logic        startOrderExecutedWithPrice,
    output logic [5:0]  trackerOut,
    output logic [7:0]  msgType,
    output logic        errUnknownType
`ifdef ITCH_DISPATCH_MSG_COUNT_EN
    ,
    output logic [31:0] msgCount
`endif
);

    localparam logic [7:0] TYPE_T = 8'h54;
    localparam logic [7:0] TYPE_A = 8'h41;
    localparam logic [7:0] TYPE_D = 8'h44;
    localparam logic [7:0] TYPE_E = 8'h45;
    localparam logic [7:0] TYPE_C = 8'h43;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_REPLAY = 2'd1,
        ST_ERROR  = 2'd2
    } state_e;

    // Returns {known, length} for a type byte.
    function automatic logic [7:0] len_lookup(input logic [7:0] t);
        logic [7:0] r;
        case (t)
            TYPE_T:  r = {1'b1, 7'(LEN_T)};
            TYPE_A:  r = {1'b1, 7'(LEN_A)};
            TYPE_D:  r = {1'b1, 7'(LEN_D)};
            TYPE_E:  r = {1'b1, 7'(LEN_E)};
            TYPE_C:  r = {1'b1, 7'(LEN_C)};
            default: r = 8'd0;
        endcase
        return r;
    endfunction

    state_e             state_q, state_d;
    logic signed [11:0] b_q, b_d;
    logic               pend_q, pend_d;
    logic [7:0]         pend_type_q, pend_type_d;
    logic [63:0]        hold_q, hold_d;
    logic [63:0]        data_out_q, data_out_d;
    logic               valid_q, valid_d;
    logic               replay_q, replay_d;
    logic               ready_q, ready_d;
    logic               start_sec_q, start_sec_d;
    logic               start_add_q, start_add_d;
    logic               start_del_q, start_del_d;
    logic               start_exe_q, start_exe_d;
    logic               start_exp_q, start_exp_d;
    logic [5:0]         tracker_q, tracker_d;
    logic [7:0]         msg_type_q, msg_type_d;
    logic               err_q, err_d;

    logic               proc_en;
    logic [63:0]        proc_word;
    logic               proc_replay;
    logic [2:0]         pos;
    logic [7:0]         cur_type;
    logic               cur_known;
    logic [6:0]         cur_len;
    logic signed [11:0] b_new;
    logic               fire;
    logic [7:0]         fire_type;
    logic [5:0]         fire_tracker;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            b_q         <= '0;
            pend_q      <= 1'b0;
            pend_type_q <= '0;
            hold_q      <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            replay_q    <= 1'b0;
            ready_q     <= 1'b1;
            start_sec_q <= 1'b0;
            start_add_q <= 1'b0;
            start_del_q <= 1'b0;
            start_exe_q <= 1'b0;
            start_exp_q <= 1'b0;
            tracker_q   <= '0;
            msg_type_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            b_q         <= b_d;
            pend_q      <= pend_d;
            pend_type_q <= pend_type_d;
            hold_q      <= hold_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            replay_q    <= replay_d;
            ready_q     <= ready_d;
            start_sec_q <= start_sec_d;
            start_add_q <= start_add_d;
            start_del_q <= start_del_d;
            start_exe_q <= start_exe_d;
            start_exp_q <= start_exp_d;
            tracker_q   <= tracker_d;
            msg_type_q  <= msg_type_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        b_d          = b_q;
        pend_d       = pend_q;
        pend_type_d  = pend_type_q;
        hold_d       = hold_q;
        data_out_d   = data_out_q;
        valid_d      = 1'b0;
        replay_d     = 1'b0;
        tracker_d    = '0;
        msg_type_d   = '0;
        err_d        = err_q;
        fire         = 1'b0;
        fire_type    = '0;
        fire_tracker = '0;
        proc_en      = 1'b0;
        proc_word    = hold_q;
        proc_replay  = 1'b0;

        case (state_q)
            ST_RUN: begin
                proc_en   = dataInValid && ready_q;
                proc_word = dataIn;
            end
            ST_REPLAY: begin
                proc_en     = 1'b1;
                proc_replay = 1'b1;
            end
            default: ;
        endcase

        pos                  = b_q[2:0];
        cur_type             = proc_word[{pos, 3'b000} +: 8];
        {cur_known, cur_len} = len_lookup(cur_type);
        b_new                = $signed({9'd0, pos}) + $signed({5'd0, cur_len}) - 12'sd8;

        if (proc_en) begin
            valid_d    = 1'b1;
            replay_d   = proc_replay;
            data_out_d = proc_word;
            state_d    = ST_RUN;
            if (b_q > 12'sd7) begin
                // Word is entirely body; a start deferred from byte 7 fires here.
                b_d = b_q - 12'sd8;
                if (pend_q) begin
                    fire      = 1'b1;
                    fire_type = pend_type_q;
                    pend_d    = 1'b0;
                end
            end else if (!cur_known) begin
                err_d    = 1'b1;
                state_d  = ST_ERROR;
                valid_d  = 1'b0;
                replay_d = 1'b0;
                pend_d   = 1'b0;
            end else if (pend_q) begin
                // Collision: fire the deferred start now, replay the word for the new type byte.
                fire      = 1'b1;
                fire_type = pend_type_q;
                pend_d    = 1'b0;
                hold_d    = proc_word;
                state_d   = ST_REPLAY;
            end else if (pos == 3'd7) begin
                pend_d      = 1'b1;
                pend_type_d = cur_type;
                b_d         = b_new;
            end else begin
                fire         = 1'b1;
                fire_type    = cur_type;
                fire_tracker = {3'(pos + 3'd1), 3'b000};
                if (b_new < 12'sd0) begin
                    hold_d  = proc_word;
                    state_d = ST_REPLAY;
                    b_d     = b_new + 12'sd8;
                end else begin
                    b_d = b_new;
                end
            end
        end

        if (fire) begin
            tracker_d  = fire_tracker;
            msg_type_d = fire_type;
        end
        start_sec_d = fire && (fire_type == TYPE_T);
        start_add_d = fire && (fire_type == TYPE_A);
        start_del_d = fire && (fire_type == TYPE_D);
        start_exe_d = fire && (fire_type == TYPE_E);
        start_exp_d = fire && (fire_type == TYPE_C);
        ready_d     = (state_d != ST_REPLAY);
    end

`ifdef ITCH_DISPATCH_MSG_COUNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 32'(fire);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign msgCount = cnt_q;
`endif

    assign dataInReady                 = ready_q;
    assign dataOut                     = data_out_q;
    assign dataOutValid                = valid_q;
    assign dataOutReplay               = replay_q;
    assign startSeconds                = start_sec_q;
    assign startAddOrder               = start_add_q;
    assign startDelete                 = start_del_q;
    assign startOrderExecuted          = start_exe_q;
    assign startOrderExecutedWithPrice = start_exp_q;
    assign trackerOut                  = tracker_q;
    assign msgType                     = msg_type_q;
    assign errUnknownType              = err_q;

endmodule

// File: tb/tb_itch_message_dispatcher.sv
// Directed bench for itch_message_dispatcher: vector table plus a handshake-driven run of ten 'T' messages.
module tb_itch_message_dispatcher;

    logic        clk;
    logic        rst;
    logic [63:0] dataIn;
    logic        dataInValid;
    logic        dataInReady;
    logic [63:0] dataOut;
    logic        dataOutValid;
    logic        dataOutReplay;
    logic        startSeconds;
    logic        startAddOrder;
    logic        startDelete;
    logic        startOrderExecuted;
    logic        startOrderExecutedWithPrice;
    logic [5:0]  trackerOut;
    logic [7:0]  msgType;
    logic        errUnknownType;
`ifdef ITCH_DISPATCH_MSG_COUNT_EN
    logic [31:0] msgCount;
`endif

    itch_message_dispatcher dut (
        .clk                         (clk),
        .rst                         (rst),
        .dataIn                      (dataIn),
        .dataInValid                 (dataInValid),
        .dataInReady                 (dataInReady),
        .dataOut                     (dataOut),
        .dataOutValid                (dataOutValid),
        .dataOutReplay               (dataOutReplay),
        .startSeconds                (startSeconds),
        .startAddOrder               (startAddOrder),
        .startDelete                 (startDelete),
        .startOrderExecuted          (startOrderExecuted),
        .startOrderExecutedWithPrice (startOrderExecutedWithPrice),
        .trackerOut                  (trackerOut),
        .msgType                     (msgType),
        .errUnknownType              (errUnknownType)
`ifdef ITCH_DISPATCH_MSG_COUNT_EN
        ,
        .msgCount                    (msgCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start vector bit order: {seconds, add, delete, executed, executedWithPrice}
    localparam logic [4:0] S_0 = 5'b00000;
    localparam logic [4:0] S_T = 5'b10000;
    localparam logic [4:0] S_A = 5'b01000;
    localparam logic [4:0] S_D = 5'b00100;
    localparam logic [4:0] S_E = 5'b00010;
    localparam logic [4:0] S_C = 5'b00001;

    typedef struct {
        logic        r;
        logic        v;
        logic [63:0] d;
        logic        e_rdy;
        logic        e_vld;
        logic        e_rep;
        logic [4:0]  e_st;
        logic [5:0]  e_trk;
        logic [7:0]  e_mt;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;

    function automatic logic [63:0] w1(input int pos, input logic [7:0] t, input logic [7:0] fill);
        logic [63:0] w;
        w = {8{fill}};
        w[pos*8 +: 8] = t;
        return w;
    endfunction

    function automatic logic [63:0] fw(input logic [7:0] fill);
        return {8{fill}};
    endfunction

    function automatic void add(input logic r, input logic v, input logic [63:0] d,
                                input logic e_rdy, input logic e_vld, input logic e_rep,
                                input logic [4:0] e_st, input logic [5:0] e_trk,
                                input logic [7:0] e_mt, input logic e_err);
        vec_t x;
        x.r = r; x.v = v; x.d = d;
        x.e_rdy = e_rdy; x.e_vld = e_vld; x.e_rep = e_rep;
        x.e_st = e_st; x.e_trk = e_trk; x.e_mt = e_mt; x.e_err = e_err;
        vecs.push_back(x);
    endfunction

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        logic [63:0] last_beat;
        logic [63:0] exp_data;
        logic [4:0]  starts;
        logic [7:0]  sb [0:55];
        logic [63:0] word;
        logic        acc;
        logic        got_del;
        int          idx;
        int          n_sec;

        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b0;
        dataIn      = '0;
        dataInValid = 1'b0;
        last_beat   = '0;

        // Reset state, including a valid word presented during reset
        add(0, 0, 64'd0,                    1, 0, 0, S_0,  0, 8'h00, 0);
        add(0, 1, w1(0, 8'h43, 8'h11),      1, 0, 0, S_0,  0, 8'h00, 0);
        // 'C' at byte 0, next type at word6 byte 4
        add(1, 1, w1(0, 8'h43, 8'h11),      1, 1, 0, S_C,  8, 8'h43, 0);
        for (int k = 0; k < 5; k++)
            add(1, 1, fw(8'h22),            1, 1, 0, S_0,  0, 8'h00, 0);
        add(1, 1, w1(4, 8'h44, 8'h33),      1, 1, 0, S_D, 40, 8'h44, 0);
        add(1, 1, fw(8'h55),                1, 1, 0, S_0,  0, 8'h00, 0);
        // 'E' at byte 7 is deferred to the next word with tracker 0
        add(1, 1, w1(7, 8'h45, 8'h66),      1, 1, 0, S_0,  0, 8'h00, 0);
        add(1, 1, fw(8'h77),                1, 1, 0, S_E,  0, 8'h45, 0);
        add(1, 1, fw(8'h78),                1, 1, 0, S_0,  0, 8'h00, 0);
        add(1, 1, fw(8'h79),                1, 1, 0, S_0,  0, 8'h00, 0);
        add(1, 1, w1(6, 8'h54, 8'h88),      1, 1, 0, S_T, 56, 8'h54, 0);
        add(1, 1, w1(3, 8'h41, 8'h99),      1, 1, 0, S_A, 32, 8'h41, 0);
        // 'T' then 'A' in one word: replay beat
        add(0, 1, fw(8'hAB),                1, 0, 0, S_0,  0, 8'h00, 0);
        add(1, 1, 64'hEEEE_41DD_DDDD_DD54,  0, 1, 0, S_T,  8, 8'h54, 0);
        add(1, 1, fw(8'h5A),                1, 1, 1, S_A, 48, 8'h41, 0);
        add(1, 1, fw(8'h5A),                1, 1, 0, S_0,  0, 8'h00, 0);
        // Deferred 'T' collides with a 'D' in the following word
        add(0, 0, 64'd0,                    1, 0, 0, S_0,  0, 8'h00, 0);
        add(1, 1, w1(0, 8'h45, 8'h01),      1, 1, 0, S_E,  8, 8'h45, 0);
        add(1, 1, fw(8'h02),                1, 1, 0, S_0,  0, 8'h00, 0);
        add(1, 1, fw(8'h03),                1, 1, 0, S_0,  0, 8'h00, 0);
        add(1, 1, w1(7, 8'h54, 8'h04),      1, 1, 0, S_0,  0, 8'h00, 0);
        add(1, 1, w1(4, 8'h44, 8'h05),      0, 1, 0, S_T,  0, 8'h54, 0);
        add(1, 1, fw(8'h06),                1, 1, 1, S_D, 40, 8'h44, 0);
        add(1, 1, fw(8'h06),                1, 1, 0, S_0,  0, 8'h00, 0);
        // Unknown type: sticky error, only reset clears it
        add(0, 0, 64'd0,                    1, 0, 0, S_0,  0, 8'h00, 0);
        add(1, 1, w1(0, 8'h7A, 8'h00),      1, 0, 0, S_0,  0, 8'h00, 1);
        add(1, 1, w1(0, 8'h54, 8'h00),      1, 0, 0, S_0,  0, 8'h00, 1);
        add(1, 1, w1(0, 8'h44, 8'h00),      1, 0, 0, S_0,  0, 8'h00, 1);
        add(0, 0, 64'd0,                    1, 0, 0, S_0,  0, 8'h00, 0);
        add(1, 1, w1(0, 8'h44, 8'h10),      1, 1, 0, S_D,  8, 8'h44, 0);
        add(1, 1, fw(8'h11),                1, 1, 0, S_0,  0, 8'h00, 0);
        add(1, 1, w1(3, 8'h43, 8'h20),      1, 1, 0, S_C, 32, 8'h43, 0);
        // Bubbles across a 'C' body, then a deferred 'D' waiting through a bubble
        add(1, 1, fw(8'h21),                1, 1, 0, S_0,  0, 8'h00, 0);
        add(1, 0, fw(8'hF0),                1, 0, 0, S_0,  0, 8'h00, 0);
        add(1, 0, fw(8'hF1),                1, 0, 0, S_0,  0, 8'h00, 0);
        add(1, 1, fw(8'h22),                1, 1, 0, S_0,  0, 8'h00, 0);
        add(1, 1, fw(8'h23),                1, 1, 0, S_0,  0, 8'h00, 0);
        add(1, 1, fw(8'h24),                1, 1, 0, S_0,  0, 8'h00, 0);
        add(1, 1, fw(8'h25),                1, 1, 0, S_0,  0, 8'h00, 0);
        add(1, 1, w1(7, 8'h44, 8'h30),      1, 1, 0, S_0,  0, 8'h00, 0);
        add(1, 0, fw(8'hF2),                1, 0, 0, S_0,  0, 8'h00, 0);
        add(1, 1, fw(8'h31),                1, 1, 0, S_D,  0, 8'h44, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst         = vecs[i].r;
            dataInValid = vecs[i].v;
            dataIn      = vecs[i].d;
            @(posedge clk);
            #1;
            starts = {startSeconds, startAddOrder, startDelete, startOrderExecuted, startOrderExecutedWithPrice};
            check("dataInReady",    i, 64'(dataInReady),    64'(vecs[i].e_rdy));
            check("dataOutValid",   i, 64'(dataOutValid),   64'(vecs[i].e_vld));
            check("dataOutReplay",  i, 64'(dataOutReplay),  64'(vecs[i].e_rep));
            check("starts",         i, 64'(starts),         64'(vecs[i].e_st));
            check("errUnknownType", i, 64'(errUnknownType), 64'(vecs[i].e_err));
            if (vecs[i].e_st != S_0) begin
                check("trackerOut", i, 64'(trackerOut), 64'(vecs[i].e_trk));
                check("msgType",    i, 64'(msgType),    64'(vecs[i].e_mt));
            end
            if (vecs[i].e_vld) begin
                exp_data  = vecs[i].e_rep ? last_beat : vecs[i].d;
                last_beat = exp_data;
                check("dataOut", i, dataOut, exp_data);
            end
        end

        // Ten back-to-back 'T' messages followed by a 'D', fed through the ready handshake
        rst         = 1'b0;
        dataInValid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 56; k++) sb[k] = 8'h00;
        for (int k = 0; k < 10; k++) sb[5*k] = 8'h54;
        sb[50]  = 8'h44;
        idx     = 0;
        n_sec   = 0;
        got_del = 1'b0;
        for (int cyc = 0; cyc < 40 && !(idx == 7 && got_del); cyc++) begin
            word = '0;
            if (idx < 7)
                for (int b = 0; b < 8; b++) word[b*8 +: 8] = sb[idx*8 + b];
            dataIn      = word;
            dataInValid = (idx < 7);
            acc         = dataInValid && dataInReady;
            @(posedge clk);
            #1;
            if (acc) idx++;
            if (startSeconds) begin
                n_sec++;
`ifdef ITCH_DISPATCH_MSG_COUNT_EN
                if (n_sec == 10) check("msgCount_at_10", 1000 + cyc, 64'(msgCount), 64'd10);
`endif
            end
            if (startDelete) begin
                got_del = 1'b1;
                check("trailing_D_tracker", 1000 + cyc, 64'(trackerOut), 64'd24);
            end
        end
        dataInValid = 1'b0;
        check("seconds_starts", 2000, 64'(n_sec),   64'd10);
        check("words_consumed", 2001, 64'(idx),     64'd7);
        check("trailing_D_seen", 2002, 64'(got_del), 64'd1);
`ifdef ITCH_DISPATCH_MSG_COUNT_EN
        check("msgCount_final", 2003, 64'(msgCount), 64'd11);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/itch_message_dispatcher.md
Name: itch_message_dispatcher

Overview:
- Front-end stage of the ITCH parser chain.
- Accepts the raw 64-bit little-endian-packed message stream, locates each message-type byte, and sends a one-beat start pulse to the matching per-type field parser. Those parsers include the order-executed-with-price parser.
- Re-registers the data word so it arrives aligned with the start pulse.
- Supplies the parser's trackerIn: the bit offset of the first body byte within that word.

Parameters:
- LEN_T, 5, total bytes of a 'T' (0x54) seconds message, type byte included.
- LEN_A, 37, total bytes of an 'A' (0x41) add-order message.
- LEN_D, 19, total bytes of a 'D' (0x44) delete-order message.
- LEN_E, 31, total bytes of an 'E' (0x45) order-executed message.
- LEN_C, 52, total bytes of a 'C' (0x43) order-executed-with-price message.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low (rst==0 resets on the clk edge).
- dataIn  in  64  stream word; byte k occupies bits [8k+7:8k].
- dataInValid  in  1  dataIn carries a word.
- dataInReady  out  1  word accepted on clk when dataInValid && dataInReady.
- dataOut  out  64  registered word presented to all parsers.
- dataOutValid  out  1  dataOut is a valid beat.
- dataOutReplay  out  1  beat repeats the previous word; parsers already mid-message ignore it.
- startSeconds, startAddOrder, startDelete, startOrderExecuted, startOrderExecutedWithPrice  out  1 each  one-hot start pulses, aligned with dataOut.
- trackerOut  out  6  bit offset of the body's first byte in dataOut; a multiple of 8.
- msgType  out  8  type byte of the message being started.
- errUnknownType  out  1  sticky; set on an unrecognised type byte.

Behaviour:
- Internal byte counter B (12 bits) = bytes remaining until the next type byte. Reset value 0, so the first accepted word holds a type byte at byte 0.
- Reset values: all outputs 0, except dataInReady=1. State=RUN, no pending start, holdWord=0.
- States: RUN, REPLAY, ERROR.
- RUN, on an accepted word with B>=8:
  - B-=8.
  - If a pending start exists, it fires on this word's output beat with trackerOut=0.
- RUN, on an accepted word with B<8:
  - Type byte t = word[8B+7:8B].
  - If p=B<7, the start fires on this word's output beat with trackerOut=8(p+1).
  - If p=7, the start is made pending with trackerOut=0 and fires on the next accepted word's beat.
  - B = p+len(t)-8.
- Collisions and same-word messages:
  - If B<0 after the update, the next type byte lies in the same word.
  - If a pending start and a new type byte occur in the same word, a collision exists.
  - In either case: latch the word to holdWord, restore B to the in-word position, enter REPLAY, and deassert dataInReady for the next cycle.
- REPLAY: one cycle.
  - Process holdWord using the RUN rules.
  - The output beat carries holdWord with dataOutReplay=1 and at most one start.
  - Return to RUN, or stay in REPLAY if yet another type byte lies in the word.
- Latency and pulse rules:
  - Exactly one cycle from acceptance to dataOut/start. dataOutValid=0 on idle cycles.
  - At most one start pulse per beat. Pulses are single-cycle.
- Unknown type byte:
  - Set errUnknownType and enter ERROR.
  - In ERROR, dataInReady=1: words are accepted and discarded, dataOutValid=0, no starts.
  - ERROR exits only via reset.
- Widths: len() is a 7-bit constant lookup; B arithmetic is signed 12-bit, with no wrap for legal lengths.
- Reset mid-message: abandons everything. The pending start and REPLAY are dropped; the next accepted word is a fresh byte-0 boundary.
- dataInValid low: the state holds and no beat is emitted. A pending start waits indefinitely.

Optional Feature:
- Macro: ITCH_DISPATCH_MSG_COUNT_EN.
- Defined:
  - Adds output msgCount[31:0], reset 0.
  - It increments by 1 on every start pulse and wraps from 0xFFFFFFFF to 0.
  - ERROR beats do not count.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then word0 byte0=0x43 with continuous words → next cycle startOrderExecutedWithPrice=1, trackerOut=8, msgType=0x43. The next type byte is expected at word6 byte4 (52 bytes); when the word6 beat is emitted, the matching start fires with trackerOut=40.
- Type 0x45 at word byte 7 → no start on that beat. The next accepted word's beat gives startOrderExecuted=1, trackerOut=0.
- Word bytes0..4 = 'T' message and byte5 = 0x41 → beat 1: startSeconds, trackerOut=8. Beat 2: dataOutReplay=1, startAddOrder, trackerOut=48. dataInReady=0 for exactly one cycle.
- Type byte 0x7A → errUnknownType=1 sticky, no further starts or valid beats. rst=0 for one cycle clears it; the next word's byte0=0x44 gives startDelete, trackerOut=8.
- dataInValid toggled 1,0,0,1 across a 'C' message → starts and B unaffected by bubbles; dataOutValid mirrors accepted words delayed by one cycle.
- With ITCH_DISPATCH_MSG_COUNT_EN: 10 back-to-back 'T' messages → msgCount=10. Undefined build: the port is absent and the bench compiles.
